area_class_scheduler: RTL and testbench

AREA_CLASS_SCHEDULER -- requirements
Module: area_class_scheduler

---
 rtl/fruit_area_pkg.sv | 14 +
 rtl/area_class_scheduler_if.sv | 15 +
 rtl/area_max_tracker.sv | 39 +++
 rtl/area_class_scheduler.sv | 117 +++++++++++
 tb/tb_area_class_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fruit_area_pkg.sv
// Shared constants and state encoding for the area class scheduler.
package fruit_area_pkg;
  localparam int NUM_REGIONS = 12;
  localparam int AREA_W      = 24;
  localparam int CLASS_W     = 4;
  localparam logic [CLASS_W-1:0] CLASS_NONE = 4'hF;
  localparam logic [CLASS_W-1:0] LAST_IDX   = CLASS_W'(NUM_REGIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/area_class_scheduler_if.sv
// Step bus between the scan sequencer and the running-maximum tracker.
// Handshake: no valid/ready; the sequencer raises step for one cycle per sample,
// clr for one cycle to restart, and nxt_* always shows the post-edge max/index.
interface area_class_scheduler_if;
  import fruit_area_pkg::*;
  logic               clr;
  logic               step;
  logic [CLASS_W-1:0] pos;
  logic [AREA_W-1:0]  sample;
  logic [AREA_W-1:0]  nxt_max;
  logic [CLASS_W-1:0] nxt_idx;

  modport master (output clr, step, pos, sample, input nxt_max, nxt_idx);
  modport slave  (input clr, step, pos, sample, output nxt_max, nxt_idx);
endinterface

// File: rtl/area_max_tracker.sv
// Compare-and-hold of the largest sample seen since the last clear, with its index.
module area_max_tracker
  import fruit_area_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  area_class_scheduler_if.slave  bus
);
  logic [AREA_W-1:0]  r_max;
  logic [CLASS_W-1:0] r_idx;
  logic [AREA_W-1:0]  w_nxt_max;
  logic [CLASS_W-1:0] w_nxt_idx;

  // Strictly-greater replace keeps the lowest index on ties.
  always_comb begin
    w_nxt_max = r_max;
    w_nxt_idx = r_idx;
    if (bus.clr) begin
      w_nxt_max = '0;
      w_nxt_idx = '0;
    end else if (bus.step && (bus.sample > r_max)) begin
      w_nxt_max = bus.sample;
      w_nxt_idx = bus.pos;
    end
  end

  assign bus.nxt_max = w_nxt_max;
  assign bus.nxt_idx = w_nxt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max <= '0;
      r_idx <= '0;
    end else begin
      r_max <= w_nxt_max;
      r_idx <= w_nxt_idx;
    end
  end
endmodule

// File: rtl/area_class_scheduler.sv
// Frame-skipping scheduler: snapshots twelve region counts at a vsync edge,
// scans them one per cycle and reports the winning region 13 cycles later.
module area_class_scheduler
  import fruit_area_pkg::*;
#(
  parameter logic [AREA_W-1:0] MIN_AREA   = 24'd2000,
  parameter int                FRAME_SKIP = 1
) (
  input  logic               pixelclk,
  input  logic               rstin,
  input  logic               i_run,
  input  logic               i_vsync,
  input  logic [AREA_W-1:0]  s0, s1, s2, s3, s4, s5,
  input  logic [AREA_W-1:0]  s6, s7, s8, s9, s10, s11,
  output logic               en,
  output logic [CLASS_W-1:0] o_class,
  output logic [AREA_W-1:0]  o_area,
  output logic               o_valid,
  output logic               o_none,
  output logic               o_busy,
  output state_t             o_dbg_state
);
  localparam int FCW = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_SKIP);

  state_t             r_state;
  logic               r_vs_prev;
  logic [FCW-1:0]     r_fcnt;
  logic               r_en;
  logic [CLASS_W-1:0] r_scan_idx;
  logic [AREA_W-1:0]  r_snap [NUM_REGIONS];
  logic               r_valid;
  logic [CLASS_W-1:0] r_class;
  logic [AREA_W-1:0]  r_area;
  logic               r_none;

  logic [AREA_W-1:0]  w_s [NUM_REGIONS];
  logic               w_edge;
  logic               w_capture;
  logic [FCW-1:0]     w_fcnt_nxt;

  assign w_s = '{s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11};
  assign w_edge     = i_vsync && !r_vs_prev;
  assign w_fcnt_nxt = (r_fcnt == FC_LAST) ? '0 : r_fcnt + 1'b1;
  // en is the value from before this edge's update, so the wrap edge itself is never captured.
  assign w_capture  = w_edge && r_en && (r_state == ST_IDLE);

  area_class_scheduler_if u_bus ();
  assign u_bus.clr    = w_capture;
  assign u_bus.step   = (r_state == ST_SCAN);
  assign u_bus.pos    = r_scan_idx;
  assign u_bus.sample = r_snap[r_scan_idx];

  area_max_tracker u_trk (
    .clk (pixelclk),
    .rst (rstin),
    .bus (u_bus.slave)
  );

  always_ff @(posedge pixelclk) begin
    if (rstin) begin
      r_state    <= ST_IDLE;
      r_vs_prev  <= 1'b0;
      r_fcnt     <= FC_LAST;
      r_en       <= 1'b0;
      r_scan_idx <= '0;
      r_valid    <= 1'b0;
      r_class    <= CLASS_NONE;
      r_area     <= '0;
      r_none     <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) r_snap[i] <= '0;
    end else begin
      r_vs_prev <= i_vsync;
      r_valid   <= 1'b0;
      if (w_edge) begin
        r_fcnt <= w_fcnt_nxt;
        r_en   <= (w_fcnt_nxt == '0) && i_run;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            for (int i = 0; i < NUM_REGIONS; i++) r_snap[i] <= w_s[i];
            r_scan_idx <= '0;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Last sample is folded in through the tracker's next-state view.
          if (r_scan_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_area  <= u_bus.nxt_max;
            if (u_bus.nxt_max >= MIN_AREA) begin
              r_class <= u_bus.nxt_idx;
              r_none  <= 1'b0;
            end else begin
              r_class <= CLASS_NONE;
              r_none  <= 1'b1;
            end
          end else begin
            r_scan_idx <= r_scan_idx + 4'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign en          = r_en;
  assign o_valid     = r_valid;
  assign o_class     = r_class;
  assign o_area      = r_area;
  assign o_none      = r_none;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_area_class_scheduler.sv
// Bench for area_class_scheduler: table of frames, corner-case sequences, result scoreboard.
module tb_area_class_scheduler;
  import fruit_area_pkg::*;

  localparam int RW = 29;
  localparam logic [RW-1:0] RST_RES = {4'hF, 24'd0, 1'b0};

  typedef struct packed {
    logic [287:0] s;
    logic [3:0]   cls;
    logic [23:0]  area;
    logic         none;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst, run, vs0, vs1;
  logic [23:0] s [12];

  logic        d0_en, d0_valid, d0_none, d0_busy;
  logic [3:0]  d0_class;
  logic [23:0] d0_area;
  state_t      d0_state;
  logic        d1_en, d1_valid, d1_none, d1_busy;
  logic [3:0]  d1_class;
  logic [23:0] d1_area;
  state_t      d1_state;

  area_class_scheduler #(.MIN_AREA(24'd2000), .FRAME_SKIP(0)) dut0 (
    .pixelclk(clk), .rstin(rst), .i_run(run), .i_vsync(vs0),
    .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .s5(s[5]),
    .s6(s[6]), .s7(s[7]), .s8(s[8]), .s9(s[9]), .s10(s[10]), .s11(s[11]),
    .en(d0_en), .o_class(d0_class), .o_area(d0_area), .o_valid(d0_valid),
    .o_none(d0_none), .o_busy(d0_busy), .o_dbg_state(d0_state)
  );

  area_class_scheduler #(.MIN_AREA(24'd2000), .FRAME_SKIP(1)) dut1 (
    .pixelclk(clk), .rstin(rst), .i_run(run), .i_vsync(vs1),
    .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .s5(s[5]),
    .s6(s[6]), .s7(s[7]), .s8(s[8]), .s9(s[9]), .s10(s[10]), .s11(s[11]),
    .en(d1_en), .o_class(d1_class), .o_area(d1_area), .o_valid(d1_valid),
    .o_none(d1_none), .o_busy(d1_busy), .o_dbg_state(d1_state)
  );

  area_class_scheduler_if t_if ();
  area_max_tracker u_trk (.clk(clk), .rst(rst), .bus(t_if.slave));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q0[$], exp_q1[$];
  int            cyc_q0[$], cyc_q1[$];
  logic [RW-1:0] last0, last1, act0, act1, e0, e1;
  int            ec0, ec1;

  assign act0 = {d0_class, d0_area, d0_none};
  assign act1 = {d1_class, d1_area, d1_none};

  always @(negedge clk) begin
    if (rst) begin
      last0 = RST_RES;
    end else if (d0_valid) begin
      n_vec++;
      if (exp_q0.size() == 0) begin
        n_err++;
        $display("FAIL d0_unexpected_valid: got class=%h area=%0d at cyc %0d, required no o_valid",
                 act0[28:25], act0[24:1], cyc);
        last0 = act0;
      end else begin
        e0  = exp_q0.pop_front();
        ec0 = cyc_q0.pop_front();
        if (act0 !== e0 || cyc != ec0) begin
          n_err++;
          $display("FAIL d0_result: got class=%h area=%0d none=%0b cyc=%0d, required class=%h area=%0d none=%0b cyc=%0d",
                   act0[28:25], act0[24:1], act0[0], cyc, e0[28:25], e0[24:1], e0[0], ec0);
        end
        last0 = e0;
      end
    end else if (act0 !== last0) begin
      n_err++;
      $display("FAIL d0_hold: got %h, required %h at cyc %0d", act0, last0, cyc);
      last0 = act0;
    end

    if (rst) begin
      last1 = RST_RES;
    end else if (d1_valid) begin
      n_vec++;
      if (exp_q1.size() == 0) begin
        n_err++;
        $display("FAIL d1_unexpected_valid: got class=%h area=%0d at cyc %0d, required no o_valid",
                 act1[28:25], act1[24:1], cyc);
        last1 = act1;
      end else begin
        e1  = exp_q1.pop_front();
        ec1 = cyc_q1.pop_front();
        if (act1 !== e1 || cyc != ec1) begin
          n_err++;
          $display("FAIL d1_result: got class=%h area=%0d none=%0b cyc=%0d, required class=%h area=%0d none=%0b cyc=%0d",
                   act1[28:25], act1[24:1], act1[0], cyc, e1[28:25], e1[24:1], e1[0], ec1);
        end
        last1 = e1;
      end
    end else if (act1 !== last1) begin
      n_err++;
      $display("FAIL d1_hold: got %h, required %h at cyc %0d", act1, last1, cyc);
      last1 = act1;
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [287:0] fill(input logic [23:0] v);
    logic [287:0] f;
    for (int i = 0; i < 12; i++) f[i*24 +: 24] = v;
    return f;
  endfunction

  function automatic logic [287:0] poke(input logic [287:0] f, input int i, input logic [23:0] v);
    logic [287:0] g;
    g = f;
    g[i*24 +: 24] = v;
    return g;
  endfunction

  task automatic apply_s(input logic [287:0] f);
    for (int i = 0; i < 12; i++) s[i] = f[i*24 +: 24];
  endtask

  // Raises vsync for one cycle (cycle T); returns at the negedge inside T+1.
  task automatic pulse(input int which, input bit cap, input logic [RW-1:0] e);
    @(negedge clk);
    if (which == 0) vs0 = 1'b1; else vs1 = 1'b1;
    if (cap) begin
      if (which == 0) begin exp_q0.push_back(e); cyc_q0.push_back(cyc + 13); end
      else            begin exp_q1.push_back(e); cyc_q1.push_back(cyc + 13); end
    end
    @(negedge clk);
    vs0 = 1'b0;
    vs1 = 1'b0;
  endtask

  task automatic drain(input int which);
    int k;
    k = 0;
    while (((which == 0) ? exp_q0.size() : exp_q1.size()) > 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (((which == 0) ? exp_q0.size() : exp_q1.size()) > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got no o_valid on dut%0d within 40 cycles, required one", which);
      exp_q0.delete(); cyc_q0.delete(); exp_q1.delete(); cyc_q1.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl [8];

  initial begin
    logic [287:0] f;
    int w;
    logic [23:0] a;

    tbl[0] = '{poke(fill(24'd100), 5, 24'd5000),  4'd5,  24'd5000,    1'b0};
    tbl[1] = '{poke(poke(fill(24'd500), 3, 24'd9000), 7, 24'd9000), 4'd3, 24'd9000, 1'b0};
    tbl[2] = '{poke(fill(24'd10), 8, 24'd1999),   4'hF,  24'd1999,    1'b1};
    tbl[3] = '{poke(fill(24'd10), 8, 24'd2000),   4'd8,  24'd2000,    1'b0};
    tbl[4] = '{fill(24'd0),                       4'hF,  24'd0,       1'b1};
    tbl[5] = '{poke(fill(24'd1), 11, 24'hFFFFFF), 4'd11, 24'hFFFFFF,  1'b0};
    tbl[6] = '{fill(24'd2000),                    4'd0,  24'd2000,    1'b0};
    tbl[7] = '{poke(poke(fill(24'd3), 0, 24'h800000), 6, 24'h7FFFFF), 4'd0, 24'h800000, 1'b0};

    rst = 1'b1; run = 1'b1; vs0 = 1'b0; vs1 = 1'b0;
    apply_s(fill(24'd0));
    t_if.clr = 1'b0; t_if.step = 1'b0; t_if.pos = '0; t_if.sample = '0;
    repeat (3) @(negedge clk);

    chk("rst_en0", d0_en, 0);
    chk("rst_valid0", d0_valid, 0);
    chk("rst_busy0", d0_busy, 0);
    chk("rst_none0", d0_none, 0);
    chk("rst_class0", d0_class, 4'hF);
    chk("rst_area0", d0_area, 0);
    chk("rst_state0", d0_state, ST_IDLE);
    chk("rst_en1", d1_en, 0);
    rst = 1'b0;

    // tracker on its own bus
    t_if.clr = 1'b1;
    @(negedge clk);
    t_if.clr = 1'b0; t_if.step = 1'b1; t_if.pos = 4'd0; t_if.sample = 24'd5;
    #1 chk("trk_first_max", t_if.nxt_max, 5);
    @(negedge clk);
    t_if.pos = 4'd1; t_if.sample = 24'd9;
    #1 chk("trk_grow_idx", t_if.nxt_idx, 1);
    @(negedge clk);
    t_if.pos = 4'd2; t_if.sample = 24'd9;
    #1 chk("trk_tie_idx", t_if.nxt_idx, 1);
    @(negedge clk);
    t_if.pos = 4'd3; t_if.sample = 24'd3;
    #1 chk("trk_less_max", t_if.nxt_max, 9);
    @(negedge clk);
    t_if.step = 1'b0; t_if.clr = 1'b1;
    #1 chk("trk_clr_max", t_if.nxt_max, 0);
    @(negedge clk);
    t_if.clr = 1'b0;

    // first edge after reset: enables, never captures
    pulse(0, 1'b0, '0);
    chk("first_edge_en", d0_en, 1);
    repeat (16) @(negedge clk);
    chk("first_edge_busy", d0_busy, 0);

    for (int v = 0; v < 8; v++) begin
      apply_s(tbl[v].s);
      pulse(0, 1'b1, {tbl[v].cls, tbl[v].area, tbl[v].none});
      if (v == 0) begin
        chk("scan_busy", d0_busy, 1);
        chk("scan_state", d0_state, ST_SCAN);
      end
      drain(0);
      repeat (2) @(negedge clk);
    end

    // second edge at T+5 is ignored for capture
    apply_s(poke(fill(24'd0), 2, 24'd3000));
    pulse(0, 1'b1, {4'd2, 24'd3000, 1'b0});
    repeat (4) @(negedge clk);
    vs0 = 1'b1;
    @(negedge clk);
    vs0 = 1'b0;
    drain(0);
    repeat (16) @(negedge clk);
    chk("scan_edge_en", d0_en, 1);

    // reset at T+6 aborts the scan
    apply_s(poke(fill(24'd0), 9, 24'd8000));
    pulse(0, 1'b0, '0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", d0_valid, 0);
    chk("midrst_busy", d0_busy, 0);
    chk("midrst_class", d0_class, 4'hF);
    chk("midrst_en", d0_en, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_en_hold", d0_en, 0);
    pulse(0, 1'b0, '0);
    chk("midrst_en_edge", d0_en, 1);
    apply_s(poke(fill(24'd0), 0, 24'd2500));
    pulse(0, 1'b1, {4'd0, 24'd2500, 1'b0});
    drain(0);
    repeat (2) @(negedge clk);

    // i_run low: current frame still scanned, en drops
    run = 1'b0;
    apply_s(poke(fill(24'd0), 4, 24'd4444));
    pulse(0, 1'b1, {4'd4, 24'd4444, 1'b0});
    chk("run_off_en", d0_en, 0);
    drain(0);
    pulse(0, 1'b0, '0);
    chk("run_off_en2", d0_en, 0);
    repeat (16) @(negedge clk);
    run = 1'b1;

    // FRAME_SKIP=1: en alternates, captures on even edges
    for (int k = 1; k <= 6; k++) begin
      w = $urandom_range(0, 11);
      a = 24'($urandom_range(2000, 16777215));
      for (int i = 0; i < 12; i++) s[i] = 24'($urandom_range(0, 1999));
      s[w] = a;
      pulse(1, (k % 2) == 0, {4'(w), a, 1'b0});
      chk("skip_en", d1_en, (k % 2));
      drain(1);
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
